// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier built around a carry-look-ahead adder.
// One operand pair is accepted per handshake. The product appears WIDTH clocks later
// and is held until the consumer takes it.

// Flattened carry-look-ahead adder: s = a + b + y, c = carry-out.
module carry_look_ahead #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             y,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_carry;

    // Carry into bit top+1, expanded as a sum of generate/propagate products
    // rather than rippled through the lower carries.
    function automatic logic la_carry(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             cin,
        input int               top
    );
        logic any;
        logic term;
        any = 1'b0;
        for (int j = 0; j <= top; j++) begin
            term = g[j];
            for (int k = j + 1; k <= top; k++) begin
                term = term & p[k];
            end
            any = any | term;
        end
        term = cin;
        for (int k = 0; k <= top; k++) begin
            term = term & p[k];
        end
        return any | term;
    endfunction

    assign w_g        = a & b;
    assign w_p        = a ^ b;
    assign w_carry[0] = y;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_carry[gi+1] = la_carry(w_g, w_p, y, gi);
            assign s[gi]         = w_p[gi] ^ w_carry[gi];
        end
    endgenerate

    assign c = w_carry[WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_accept;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
        .a (r_acc_hi),
        .b (w_addend),
        .y (1'b0),
        .s (w_sum),
        .c (w_cout)
    );

    // Status outputs decode the state only; in_ready follows out_ready in DONE
    // so a new pair can be loaded on the same edge the product retires.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign product   = {r_acc_hi, r_acc_lo};
    assign w_accept  = in_valid && in_ready;

    // Control FSM and datapath: load on accept, then one add-and-shift step per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_mcand  <= op_a;
                        r_acc_hi <= '0;
                        r_acc_lo <= op_b;
                        r_count  <= CNT_LAST;
                        r_state  <= S_RUN;
                    end else if ((r_state == S_DONE) && out_ready) begin
                        // Product stays in the accumulator; only out_valid drops.
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // The carry-out becomes the new MSB so no product bit is lost.
                    {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8): directed table, multi-cycle
// corner sequences and a randomised stream checked through a scoreboard queue.
module tb_shift_add_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_accepted = 0;
    int n_retired = 0;
    int n_dropped = 0;
    logic [2*W-1:0] last_product = '0;
    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: handshakes are observed at the negedge, i.e. just before the edge
    // that completes them. Reset discards anything in flight.
    always @(negedge clk) begin
        if (rst) begin
            n_dropped += sb_q.size();
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no output at %0t", product, $time);
                end else begin
                    check("sb_product", 32'(product), 32'(sb_q.pop_front()));
                    n_retired++;
                    last_product = product;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back((2*W)'(op_a) * (2*W)'(op_b));
                n_accepted++;
            end
        end
    end

    // Present a pair from a posedge+1 point and hold it until the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every accepted pair has been retired.
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 32'd1);
    endtask

    initial begin
        bit seen;
        int cyc;
        int target;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
        vecs[2] = '{8'h00,  8'hA5,  16'h0000};
        vecs[3] = '{8'h01,  8'h80,  16'h0080};
        vecs[4] = '{8'h80,  8'h02,  16'h0100};
        vecs[5] = '{8'hAA,  8'h55,  16'h3872};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);

        // Latency and busy duration for 13*11
        issue(8'd13, 8'd11);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_out_valid_low", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_out_valid_high", 32'(out_valid), 32'd1);
        check("lat_busy_low", 32'(busy), 32'd0);
        check("lat_product", 32'(product), 32'h008F);
        drain();

        // Directed table
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].a, vecs[v].b);
            drain();
            check("tbl_product", 32'(last_product), 32'(vecs[v].exp));
            $display("vec %0d: %0d * %0d -> 0x%04h", v, vecs[v].a, vecs[v].b, last_product);
        end

        // Backpressure: product held, further pairs refused
        out_ready = 1'b0;
        issue(8'd200, 8'd3);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            op_a = 8'd9;
            op_b = 8'd9;
            @(negedge clk);
            check("bp_product_hold", 32'(product), 32'h0258);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_hold", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        op_a = 8'd7;
        op_b = 8'd6;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_out_valid_low", 32'(out_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        drain();
        check("b2b_product", 32'(last_product), 32'h002A);

        // Reset in the 4th RUN cycle of 0xFF*0xFF
        issue(8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_product", 32'(product), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        issue(8'd2, 8'd3);
        drain();
        check("post_rst_product", 32'(last_product), 32'h0006);

        // Random stream with random valid/ready duty
        target = n_accepted + 1000;
        cyc = 0;
        while (n_accepted < target && cyc < 40000) begin
            @(posedge clk);
            #1;
            in_valid = $urandom_range(0, 1) == 1;
            op_a = W'($urandom);
            op_b = W'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            cyc++;
        end
        check("rand_all_accepted", 32'(n_accepted >= target), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("no_loss_no_dup", 32'(n_retired + n_dropped), 32'(n_accepted));
        $display("random: %0d accepted, %0d retired, %0d dropped by reset", n_accepted, n_retired, n_dropped);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
